// File: rtl/sram_stage_sequencer.sv
// Hands the single SRAM controller port to NUM_STAGES clients in order, then to the VGA reader.
// Optional watchdog/ERROR state is compiled in with `define STAGE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for go
// DELAY   | START_DELAY-cycle settle time before stage 0
// RUN     | active_stage owns the SRAM until its stage_done
// HANDOFF | one idle cycle between stages, no write in flight
// DISPLAY | all stages done, SRAM handed to the VGA reader
// ERROR   | watchdog fired (STAGE_TIMEOUT_EN only), left by reset
`timescale 1ns/1ps

module sram_stage_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int START_DELAY = 10,
  parameter int TIMEOUT_W   = 26,
  localparam int AS_W       = $clog2(NUM_STAGES) + 1
) (
  input  logic                         CLOCK_50_I,
  input  logic                         resetn,
  input  logic                         go,
  input  logic [NUM_STAGES*ADDR_W-1:0] client_address,
  input  logic [NUM_STAGES*DATA_W-1:0] client_wdata,
  input  logic [NUM_STAGES-1:0]        client_we_n,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [TIMEOUT_W-1:0]         timeout_limit,
  output logic [NUM_STAGES-1:0]        stage_start,
  output logic [ADDR_W-1:0]            SRAM_address,
  output logic [DATA_W-1:0]            SRAM_write_data,
  output logic                         SRAM_we_n,
  output logic [AS_W-1:0]              active_stage,
  output logic                         busy,
  output logic                         display_enable,
  output logic                         error
);

  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [AS_W-1:0] LAST_STAGE = AS_W'(NUM_STAGES - 1);

`ifdef STAGE_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_RUN, S_HANDOFF, S_DISPLAY, S_ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_RUN, S_HANDOFF, S_DISPLAY
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [AS_W-1:0]   active_q, active_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_n_q, we_n_d;

  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              we_n_sel;
  logic              done_sel;

`ifdef STAGE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic                 wd_fire;

  assign wd_inc  = (wd_q == {TIMEOUT_W{1'b1}}) ? wd_q : wd_q + 1'b1;
  assign wd_fire = (timeout_limit != '0) && (wd_inc == timeout_limit);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_limit;
`endif

  // Only the active stage's fields and done are ever visible to the rest of the logic.
  always_comb begin
    addr_sel    = '0;
    wdata_sel   = '0;
    we_n_sel    = 1'b1;
    done_sel    = 1'b0;
    stage_start = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (active_q == AS_W'(k)) begin
        addr_sel       = client_address[k*ADDR_W +: ADDR_W];
        wdata_sel      = client_wdata[k*DATA_W +: DATA_W];
        we_n_sel       = client_we_n[k];
        done_sel       = stage_done[k];
        stage_start[k] = (state_q == S_RUN);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    dly_d    = dly_q;
    addr_d   = '0;
    wdata_d  = '0;
    we_n_d   = 1'b1;
`ifdef STAGE_TIMEOUT_EN
    wd_d     = wd_q;
`endif
    case (state_q)
      S_IDLE, S_DISPLAY: begin
        if (go) begin
          state_d  = S_DELAY;
          active_d = '0;
          dly_d    = DLY_W'(START_DELAY - 1);
        end
      end
      S_DELAY: begin
        if (dly_q == '0) begin
          state_d  = S_RUN;
          active_d = '0;
`ifdef STAGE_TIMEOUT_EN
          wd_d     = '0;
`endif
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      S_RUN: begin
`ifdef STAGE_TIMEOUT_EN
        wd_d = wd_inc;
`endif
        // Leaving RUN loads idle bus values so no write spills past the stage.
        if (done_sel) begin
          state_d = S_HANDOFF;
        end
`ifdef STAGE_TIMEOUT_EN
        else if (wd_fire) begin
          state_d = S_ERROR;
        end
`endif
        else begin
          addr_d  = addr_sel;
          wdata_d = wdata_sel;
          we_n_d  = we_n_sel;
        end
      end
      S_HANDOFF: begin
        if (active_q == LAST_STAGE) begin
          state_d = S_DISPLAY;
        end else begin
          state_d  = S_RUN;
          active_d = active_q + 1'b1;
`ifdef STAGE_TIMEOUT_EN
          wd_d     = '0;
`endif
        end
      end
`ifdef STAGE_TIMEOUT_EN
      S_ERROR: state_d = S_ERROR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      dly_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_n_q   <= 1'b1;
`ifdef STAGE_TIMEOUT_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      dly_q    <= dly_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_n_q   <= we_n_d;
`ifdef STAGE_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign active_stage    = active_q;
  assign busy            = (state_q == S_DELAY) || (state_q == S_RUN) || (state_q == S_HANDOFF);
  assign display_enable  = (state_q == S_DISPLAY);
`ifdef STAGE_TIMEOUT_EN
  assign error           = (state_q == S_ERROR);
`else
  assign error           = 1'b0;
`endif

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Bench for sram_stage_sequencer: random clients/dones checked against a timeline model
// derived from stage latencies (start cycles, handoff gaps, display entry).
`timescale 1ns/1ps

module tb_sram_stage_sequencer;
  localparam int NS  = 3;
  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int SD  = 10;
  localparam int TW  = 26;
  localparam int ASW = $clog2(NS) + 1;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              go = 1'b0;
  logic [NS*AW-1:0]  client_address = '0;
  logic [NS*DW-1:0]  client_wdata = '0;
  logic [NS-1:0]     client_we_n = '1;
  logic [NS-1:0]     stage_done = '0;
  logic [TW-1:0]     timeout_limit = '0;
  logic [NS-1:0]     stage_start;
  logic [AW-1:0]     SRAM_address;
  logic [DW-1:0]     SRAM_write_data;
  logic              SRAM_we_n;
  logic [ASW-1:0]    active_stage;
  logic              busy;
  logic              display_enable;
  logic              err_w;

  int checks = 0;
  int failures = 0;
  int lat[NS];

  always #10 clk = ~clk;

  sram_stage_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .START_DELAY(SD), .TIMEOUT_W(TW)
  ) dut (
    .CLOCK_50_I(clk), .resetn(resetn), .go(go),
    .client_address(client_address), .client_wdata(client_wdata),
    .client_we_n(client_we_n), .stage_done(stage_done), .timeout_limit(timeout_limit),
    .stage_start(stage_start), .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .active_stage(active_stage), .busy(busy),
    .display_enable(display_enable), .error(err_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_clients();
    for (int k = 0; k < NS; k++) begin
      client_address[k*AW +: AW] = AW'($urandom);
      client_wdata[k*DW +: DW]   = DW'($urandom);
      client_we_n[k]             = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_start"}, stage_start, 0);
    chk({pfx, "_addr"}, SRAM_address, 0);
    chk({pfx, "_wdata"}, SRAM_write_data, 0);
    chk({pfx, "_we"}, SRAM_we_n, 1);
    chk({pfx, "_act"}, active_stage, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_disp"}, display_enable, 0);
    chk({pfx, "_err"}, err_w, 0);
  endtask

  // One full go..DISPLAY sequence. Stage k's done is pulsed lat[k] cycles after its start.
  task automatic run_seq(input bit t2, input bit do_abort);
    int s[NS];
    int disp, cur, prv, ea, abort_t;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic pw;
    s[0] = 1 + SD;
    for (int k = 1; k < NS; k++) s[k] = s[k-1] + lat[k-1] + 2;
    disp = s[NS-1] + lat[NS-1] + 2;
    abort_t = s[1] + 4;
    prv = -1; pa = '0; pd = '0; pw = 1'b1;
    for (int t = 0; t <= disp + 3; t++) begin
      @(negedge clk);
      cur = -1;
      for (int k = 0; k < NS; k++) if (t >= s[k] && t <= s[k] + lat[k]) cur = k;
      if (t >= 1) begin
        ea = 0;
        for (int k = 0; k < NS; k++) if (t >= s[k]) ea = k;
        chk("start", stage_start, (cur >= 0) ? (1 << cur) : 0);
        chk("busy", busy, (t < disp) ? 1 : 0);
        chk("disp", display_enable, (t >= disp) ? 1 : 0);
        chk("act", active_stage, ea);
        chk("err", err_w, 0);
        if (cur >= 0 && cur == prv) begin
          chk("addr", SRAM_address, pa);
          chk("wdata", SRAM_write_data, pd);
          chk("we", SRAM_we_n, pw);
        end else begin
          chk("addr_idle", SRAM_address, 0);
          chk("we_idle", SRAM_we_n, 1);
        end
      end
      if (t2 && t == s[1] + 2) begin
        chk("t2_addr", SRAM_address, 18'h23F00);
        chk("t2_we", SRAM_we_n, 0);
      end
      if (do_abort && t == abort_t) begin
        chk("rst_pre_we", SRAM_we_n, 0);
        #3 resetn = 1'b0;
        #1 chk_reset_outputs("rst_async");
        go = 1'b0;
        stage_done = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk("post_rst_busy", busy, 0);
          chk("post_rst_start", stage_start, 0);
          chk("post_rst_disp", display_enable, 0);
          chk("post_rst_we", SRAM_we_n, 1);
        end
        return;
      end
      rand_clients();
      if (t2 && t == s[1] + 1) begin
        client_address[AW +: AW] = 18'h23F00;
        client_we_n[1] = 1'b0;
      end
      if (do_abort && cur == 1) client_we_n[1] = 1'b0;
      go = (t == 0) || (t < disp && $urandom_range(0, 7) == 0);
      stage_done = NS'($urandom);
      if (cur >= 0) stage_done[cur] = (t == s[cur] + lat[cur]);
      prv = cur;
      if (cur >= 0) begin
        pa = client_address[cur*AW +: AW];
        pd = client_wdata[cur*DW +: DW];
        pw = client_we_n[cur];
      end
    end
    go = 1'b0;
    stage_done = '0;
  endtask

`ifdef STAGE_TIMEOUT_EN
  task automatic run_timeout();
    int s0;
    bit run, fired;
    s0 = 1 + SD;
    timeout_limit = TW'(100);
    for (int t = 0; t <= s0 + 110; t++) begin
      @(negedge clk);
      if (t >= 1) begin
        run   = (t >= s0) && (t < s0 + 100);
        fired = (t >= s0 + 100);
        chk("to_err", err_w, fired);
        chk("to_start", stage_start, run ? 1 : 0);
        chk("to_busy", busy, !fired);
        chk("to_disp", display_enable, 0);
        chk("to_we", SRAM_we_n, (run && t > s0) ? 0 : 1);
      end
      rand_clients();
      client_we_n = '0;
      go = (t == 0) || (t > s0 + 100 && (t % 3) == 0);
      stage_done = NS'($urandom) & ~NS'(1);
    end
    go = 1'b0;
    stage_done = '0;
    timeout_limit = '0;
    @(negedge clk);
    resetn = 1'b0;
    #1 chk_reset_outputs("to_rst");
    @(negedge clk);
    resetn = 1'b1;
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    lat = '{20, 20, 20};
    run_seq(1'b1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NS; k++) lat[k] = $urandom_range(0, 30);
      run_seq(1'b0, 1'b0);
    end
    lat = '{0, 0, 0};
    run_seq(1'b0, 1'b0);
    lat = '{150, 1, 0};
    run_seq(1'b0, 1'b0);
    lat = '{5, 30, 5};
    run_seq(1'b0, 1'b1);
    for (int k = 0; k < NS; k++) lat[k] = $urandom_range(2, 25);
    run_seq(1'b0, 1'b0);
`ifdef STAGE_TIMEOUT_EN
    run_timeout();
    lat = '{3, 4, 5};
    run_seq(1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
